// File: rtl/img_stream_out.sv
// Raster-order readout of the processed image: fetches one channel per pixel through the
// row/col port into a small prefetch FIFO and streams it out over valid/ready with a checksum.
module img_stream_out #(
    parameter int unsigned IMG_SIZE   = 64,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CHAN_SEL   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [23:0]       in_pix_i,
    output logic [ADDR_W-1:0] row_o,
    output logic [ADDR_W-1:0] col_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [7:0]        m_data_o,
    output logic              m_last_o,
    output logic              done_o,
    output logic [15:0]       checksum_o
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(IMG_SIZE - 1);
    localparam logic [PtrW-1:0]   LastPtr = PtrW'(FIFO_DEPTH - 1);
    localparam logic [CntW-1:0]   FullCnt = CntW'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d, col_q, col_d;
    logic [8:0]        mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [7:0]        hold_q, hold_d;
    logic [15:0]       checksum_q, checksum_d;
    logic              push, pop, at_last;
    logic [7:0]        chan;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        case (CHAN_SEL)
            0:       chan = in_pix_i[7:0];
            1:       chan = in_pix_i[15:8];
            default: chan = in_pix_i[23:16];
        endcase
    end

    assign at_last   = (row_q == LastIdx) && (col_q == LastIdx);
    assign m_valid_o = (count_q != '0);
    assign pop       = m_valid_o & m_ready_i;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        push    = 1'b0;
        unique case (state_q)
            StIdle: if (start_i) state_d = StFetch;
            StFetch: begin
                // A full FIFO still accepts a push when the head leaves in the same cycle.
                push = (count_q != FullCnt) || pop;
                if (push) begin
                    if (col_q == LastIdx) begin
                        col_d = '0;
                        row_d = at_last ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (at_last) state_d = StDrain;
                end
            end
            StDrain: if ((count_q == CntW'(1)) && pop) state_d = StDone;
            StDone:  ;
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        hold_d     = hold_q;
        checksum_d = checksum_q;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop) begin
            rd_ptr_d   = ptr_inc(rd_ptr_q);
            hold_d     = mem_q[rd_ptr_q][7:0];
            checksum_d = checksum_q + {8'h00, mem_q[rd_ptr_q][7:0]};
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            row_q      <= '0;
            col_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            checksum_q <= '0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            checksum_q <= checksum_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {at_last, chan};
    end

    // Once the FIFO drains, the last byte sent stays on m_data.
    assign m_data_o   = m_valid_o ? mem_q[rd_ptr_q][7:0] : hold_q;
    assign m_last_o   = m_valid_o & mem_q[rd_ptr_q][8];
    assign row_o      = row_q;
    assign col_o      = col_q;
    assign done_o     = (state_q == StDone);
    assign checksum_o = checksum_q;

endmodule

// File: tb/tb_img_stream_out.sv
// Scoreboard bench for img_stream_out: a frame model fills an expected-beat queue at start,
// and a negedge monitor checks every accepted beat, stall stability, timing and checksum.
module tb_img_stream_out;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst, start, m_ready;
    logic [23:0] in_pix;
    logic [5:0]  row, col;
    logic        m_valid, m_last, done;
    logic [7:0]  m_data;
    logic [15:0] checksum;

    // Small instances exercising the other two channel selections.
    logic        s_rst, s_start, s_ready;
    logic [1:0]  b_row, b_col, r_row, r_col;
    logic        b_valid, b_last, b_done, r_valid, r_last, r_done;
    logic [7:0]  b_data, r_data;
    logic [15:0] b_sum, r_sum;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int beats = 0;
    int last_cyc = 0;
    int ready_mode = 0;
    int nb = 0;
    int nr = 0;
    logic [8:0]  exp_q[$];
    logic [15:0] exp_sum;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data;
    logic        prev_last;

    img_stream_out #(.IMG_SIZE(64), .ADDR_W(6), .FIFO_DEPTH(4), .CHAN_SEL(1)) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .in_pix_i(in_pix), .row_o(row), .col_o(col),
        .m_valid_o(m_valid), .m_ready_i(m_ready), .m_data_o(m_data), .m_last_o(m_last),
        .done_o(done), .checksum_o(checksum)
    );

    img_stream_out #(.IMG_SIZE(4), .ADDR_W(2), .FIFO_DEPTH(2), .CHAN_SEL(0)) u_dut_b (
        .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .in_pix_i(24'hAA550F), .row_o(b_row),
        .col_o(b_col), .m_valid_o(b_valid), .m_ready_i(s_ready), .m_data_o(b_data),
        .m_last_o(b_last), .done_o(b_done), .checksum_o(b_sum)
    );

    img_stream_out #(.IMG_SIZE(4), .ADDR_W(2), .FIFO_DEPTH(2), .CHAN_SEL(2)) u_dut_r (
        .clk_i(clk), .rst_i(s_rst), .start_i(s_start), .in_pix_i(24'hAA550F), .row_o(r_row),
        .col_o(r_col), .m_valid_o(r_valid), .m_ready_i(s_ready), .m_data_o(r_data),
        .m_last_o(r_last), .done_o(r_done), .checksum_o(r_sum)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [7:0] g_of(input int r, input int c);
        return 8'((r * 64 + c) & 255);
    endfunction

    // Image memory: G carries the ramp, R/B carry unrelated patterns.
    always_comb in_pix = {8'(int'(row) * 5 + int'(col) * 3 + 7), g_of(int'(row), int'(col)),
                          8'(~(int'(row) * 7 + int'(col)))};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_frame();
        exp_q.delete();
        exp_sum = '0;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                exp_q.push_back({(r == N - 1) && (c == N - 1), g_of(r, c)});
                exp_sum = exp_sum + 16'(g_of(r, c));
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        start = 1'b0;
        ready_mode = 0;
        exp_q.delete();
        beats = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_row"}, 32'(row), 0);
        chk({tag, "_col"}, 32'(col), 0);
        chk({tag, "_valid"}, 32'(m_valid), 0);
        chk({tag, "_data"}, 32'(m_data), 0);
        chk({tag, "_last"}, 32'(m_last), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_sum"}, 32'(checksum), 0);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                return;
            end
        end
        chk("done_timeout", 0, 1);
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       m_ready = 1'b0;
            1:       m_ready = 1'b1;
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    end

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && m_valid) begin
                chk("stall_data", 32'(m_data), 32'(prev_data));
                chk("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 32'(m_data), 32'(e[7:0]));
                    chk("beat_last", 32'(m_last), 32'(e[8]));
                    beats++;
                    if (m_last) last_cyc = cyc;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    always @(negedge clk) begin
        if (!s_rst && b_valid && s_ready) begin
            chk("chan_b", 32'(b_data), 32'h0F);
            nb++;
        end
        if (!s_rst && r_valid && s_ready) begin
            chk("chan_r", 32'(r_data), 32'hAA);
            nr++;
        end
    end

    initial begin
        int c0, dcyc;
        rst = 1'b1; start = 1'b0; m_ready = 1'b0;
        s_rst = 1'b1; s_start = 1'b0; s_ready = 1'b1;
        do_reset();
        chk_reset_vals("rst0");

        // Idle with start low.
        ready_mode = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("idle_row", 32'(row), 0);
            chk("idle_col", 32'(col), 0);
            chk("idle_valid", 32'(m_valid), 0);
            chk("idle_done", 32'(done), 0);
        end

        // Full-rate frame with latency checks.
        load_frame();
        @(posedge clk);
        #1;
        start = 1'b1;
        ready_mode = 1;
        c0 = cyc;
        wait_done(dcyc);
        chk("t1_last_cycle", 32'(last_cyc - c0), 32'(N * N + 1));
        chk("t1_done_cycle", 32'(dcyc - c0), 32'(N * N + 2));
        chk("t1_beats", 32'(beats), 32'(N * N));
        chk("t1_queue_left", 32'(exp_q.size()), 0);
        chk("t1_sum_model", 32'(checksum), 32'(exp_sum));
        chk("t1_sum_const", 32'(checksum), 32'hF800);
        repeat (5) @(negedge clk);
        chk("t1_done_sticky", 32'(done), 1);
        chk("t1_valid_after", 32'(m_valid), 0);

        // Consumer stalled from the start, then random backpressure.
        do_reset();
        load_frame();
        @(posedge clk);
        #1;
        start = 1'b1;
        ready_mode = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i >= 10) begin
                chk("t3_row", 32'(row), 0);
                chk("t3_col", 32'(col), 4);
            end
        end
        chk("t3_valid", 32'(m_valid), 1);
        chk("t3_data", 32'(m_data), 32'(g_of(0, 0)));
        chk("t3_last", 32'(m_last), 0);
        start = 1'b0;
        ready_mode = 2;
        wait_done(dcyc);
        chk("t2_beats", 32'(beats), 32'(N * N));
        chk("t2_queue_left", 32'(exp_q.size()), 0);
        chk("t2_sum_model", 32'(checksum), 32'(exp_sum));
        chk("t2_sum_const", 32'(checksum), 32'hF800);

        // Reset mid-frame, then a clean restart.
        do_reset();
        load_frame();
        @(posedge clk);
        #1;
        start = 1'b1;
        ready_mode = 2;
        for (int i = 0; i < 5000 && beats < 1000; i++) @(negedge clk);
        chk("t5_reached_1000", 32'(beats >= 1000), 1);
        do_reset();
        chk_reset_vals("t5_rst");
        load_frame();
        @(posedge clk);
        #1;
        start = 1'b1;
        ready_mode = 1;
        wait_done(dcyc);
        chk("t5_beats", 32'(beats), 32'(N * N));
        chk("t5_sum_const", 32'(checksum), 32'hF800);

        // Channel selection B and R on small images.
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        s_start = 1'b1;
        repeat (60) @(negedge clk);
        chk("chan_b_beats", 32'(nb), 16);
        chk("chan_r_beats", 32'(nr), 16);
        chk("chan_b_done", 32'(b_done), 1);
        chk("chan_r_done", 32'(r_done), 1);
        chk("chan_b_sum", 32'(b_sum), 32'h00F0);
        chk("chan_r_sum", 32'(r_sum), 32'h0AA0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
